// File: rtl/uart_receiver_pkg.sv
// uart_receiver_pkg
//   Shared definitions for the UART receiver: receive FSM state encoding and
//   the bit-timing constants (16x oversampling, mid-bit sample phase, 8 data
//   bits) used by uart_receiver.
package uart_receiver_pkg;

    localparam int OVERSAMPLE   = 16;
    localparam int SAMPLE_PHASE = 7;
    localparam int DATA_BITS    = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } state_t;

endpackage

// File: rtl/uart_receiver_fifo.sv
// uart_receiver_fifo
//   Receive FIFO for uart_receiver. DEPTH must be a power of two, 2 or more.
//   Pointers carry one extra wrap bit; full when the wrap bits differ and the
//   index bits match. A push into a full FIFO is dropped and reported on
//   `drop`, unless a pop is accepted on the same cycle, which frees the slot.
//
// Ports
//   clk_sys   : clock
//   reset     : asynchronous active-high reset (FIFO empty)
//   push      : write push_data this cycle
//   push_data : byte to store
//   pop       : remove the head byte (ignored when empty)
//   rd_data   : head byte, 0 when empty
//   valid     : FIFO not empty
//   drop      : push lost because the FIFO was full
module uart_receiver_fifo #(
    parameter int DEPTH = 16
) (
    input  logic       clk_sys,
    input  logic       reset,
    input  logic       push,
    input  logic [7:0] push_data,
    input  logic       pop,
    output logic [7:0] rd_data,
    output logic       valid,
    output logic       drop
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    logic [7:0]  mem_q [DEPTH];
    logic        empty, full, pop_ok, push_ok;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    // A same-cycle pop makes room, so a push into a full FIFO still lands.
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);
    assign drop    = push && !push_ok;

    assign valid   = !empty;
    assign rd_data = empty ? 8'h00 : mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/uart_receiver.sv
// uart_receiver
//   8N1 UART receiver with 16x oversampling. rx is synchronized into clk_sys,
//   a tick generator divides the ce enable by (divisor+1), and the receive
//   FSM samples each bit at phase 7 of 16. Accepted bytes are queued for the
//   host; framing errors and lost bytes raise sticky flags.
//
//   Build option UART_RECEIVER_FIFO_EN: when defined, received bytes go into
//   a FIFO_DEPTH-entry uart_receiver_fifo; when undefined, a single holding
//   register is used instead and FIFO_DEPTH has no effect on the datapath.
//
// Ports
//   clk_sys   : system clock (only clock)
//   reset     : asynchronous active-high reset
//   ce        : clock enable; bit timing counts ce cycles
//   divisor   : ce cycles per 1/16 bit, minus 1
//   rx        : raw serial input, idles high
//   rx_data   : byte at the head of the receive buffer (0 when empty)
//   rx_valid  : receive buffer not empty
//   rx_rd     : pop the head byte
//   frame_err : sticky, stop bit sampled low
//   overrun   : sticky, a byte was dropped because the buffer was full
//   err_clr   : clears frame_err and overrun (a same-cycle new error wins)
//   busy      : FSM not in IDLE
module uart_receiver
    import uart_receiver_pkg::*;
#(
    parameter int FIFO_DEPTH = 16
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        ce,
    input  logic [15:0] divisor,
    input  logic        rx,
    output logic [7:0]  rx_data,
    output logic        rx_valid,
    input  logic        rx_rd,
    output logic        frame_err,
    output logic        overrun,
    input  logic        err_clr,
    output logic        busy
);

    localparam int PHASE_W = $clog2(OVERSAMPLE);
    localparam int BITS_W  = $clog2(DATA_BITS);

    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_depth_check
        $error("uart_receiver: FIFO_DEPTH must be a power of two, 2 or more");
    end

    state_t               state_q, state_d;
    logic                 rx_meta_q, rx_meta_d;
    logic                 rx_sync_q, rx_sync_d;
    logic [15:0]          tick_cnt_q, tick_cnt_d;
    logic [PHASE_W-1:0]   phase_q, phase_d;
    logic [BITS_W-1:0]    bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 frame_err_q, frame_err_d;
    logic                 overrun_q, overrun_d;

    logic tick, at_sample, tick_reload, push, frame_set, drop;

    assign tick      = ce && (tick_cnt_q == 16'd0);
    assign at_sample = tick && (phase_q == PHASE_W'(SAMPLE_PHASE));

    always_comb begin
        rx_meta_d   = rx;
        rx_sync_d   = rx_meta_q;
        state_d     = state_q;
        phase_d     = phase_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        tick_reload = 1'b0;
        push        = 1'b0;
        frame_set   = 1'b0;

        // The phase counter free-runs modulo 16 once a frame starts, so the
        // phase-7 sample repeats every 16 ticks without re-aligning per bit.
        if (tick && state_q != IDLE && state_q != BREAK) phase_d = phase_q + 1'b1;

        unique case (state_q)
            IDLE: begin
                if (!rx_sync_q) begin
                    state_d     = START;
                    phase_d     = '0;
                    tick_reload = 1'b1;
                end
            end
            START: begin
                if (at_sample) begin
                    if (rx_sync_q) begin
                        state_d = IDLE;
                    end else begin
                        state_d   = DATA;
                        bit_cnt_d = '0;
                    end
                end
            end
            DATA: begin
                if (at_sample) begin
                    shift_d   = {rx_sync_q, shift_q[DATA_BITS-1:1]};
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == BITS_W'(DATA_BITS - 1)) state_d = STOP;
                end
            end
            STOP: begin
                if (at_sample) begin
                    if (rx_sync_q) begin
                        push    = 1'b1;
                        state_d = IDLE;
                    end else begin
                        frame_set = 1'b1;
                        state_d   = BREAK;
                    end
                end
            end
            BREAK: begin
                if (rx_sync_q) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        tick_cnt_d = tick_cnt_q;
        if (tick_reload)    tick_cnt_d = divisor;
        else if (tick)      tick_cnt_d = divisor;
        else if (ce)        tick_cnt_d = tick_cnt_q - 16'd1;

        frame_err_d = frame_set | (frame_err_q & ~err_clr);
        overrun_d   = drop | (overrun_q & ~err_clr);
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            rx_meta_q   <= 1'b1;
            rx_sync_q   <= 1'b1;
            tick_cnt_q  <= '0;
            phase_q     <= '0;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            rx_meta_q   <= rx_meta_d;
            rx_sync_q   <= rx_sync_d;
            tick_cnt_q  <= tick_cnt_d;
            phase_q     <= phase_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

`ifdef UART_RECEIVER_FIFO_EN
    uart_receiver_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk_sys  (clk_sys),
        .reset    (reset),
        .push     (push),
        .push_data(shift_q),
        .pop      (rx_rd),
        .rd_data  (rx_data),
        .valid    (rx_valid),
        .drop     (drop)
    );
`else
    // Single-entry holding register: same push/pop/drop rules as the FIFO.
    logic [7:0] hold_q, hold_d;
    logic       hold_full_q, hold_full_d;
    logic       hold_pop, hold_push;

    assign hold_pop  = rx_rd && hold_full_q;
    assign hold_push = push && (!hold_full_q || hold_pop);
    assign drop      = push && !hold_push;
    assign rx_valid  = hold_full_q;
    assign rx_data   = hold_full_q ? hold_q : 8'h00;

    always_comb begin
        hold_d      = hold_push ? shift_q : hold_q;
        hold_full_d = hold_full_q;
        if (hold_push)     hold_full_d = 1'b1;
        else if (hold_pop) hold_full_d = 1'b0;
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            hold_q      <= '0;
            hold_full_q <= 1'b0;
        end else begin
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
        end
    end
`endif

    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: doc/uart_receiver.md
UART_RECEIVER -- requirements
Module: uart_receiver

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 16, receive FIFO depth in bytes; must be a power of two, 2 or more.
REQ-002 SHALL have port clk_sys, input, 1, system clock; the only clock.
REQ-003 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port ce, input, 1, 28 MHz clock enable; all bit timing counts ce cycles.
REQ-005 SHALL have port divisor, input, 16, ce cycles per 1/16 bit, minus 1.
REQ-006 SHALL have port rx, input, 1, raw asynchronous serial line; idles high.
REQ-007 SHALL have port rx_data, output, 8, byte at the head of the FIFO.
REQ-008 SHALL have port rx_valid, output, 1, FIFO not empty.
REQ-009 SHALL have port rx_rd, input, 1, pops the head byte on a clk_sys cycle where rx_valid=1.
REQ-010 SHALL have port frame_err, output, 1, sticky framing-error flag.
REQ-011 SHALL have port overrun, output, 1, sticky flag: a byte was lost because the FIFO was full.
REQ-012 SHALL have port err_clr, input, 1, clears frame_err and overrun.
REQ-013 SHALL have port busy, output, 1, high while the FSM is not in IDLE.

Function
REQ-014 SHALL pass rx through a 2-flop synchronizer on clk_sys, reset to 1; all decisions use the synchronized value.
REQ-015 SHALL generate a tick on a ce cycle when the tick counter is 0, then reload the counter with divisor; divisor=0 gives a tick on every ce.
REQ-016 SHALL use FSM states IDLE, START, DATA, STOP, BREAK; the bit-phase counter (0..15) advances on each tick.
REQ-017 IDLE: synchronized rx=0 -> START, with the phase counter cleared and the tick counter reloaded.
REQ-018 START: at phase 7, rx=1 -> IDLE (glitch rejected, nothing logged); rx=0 -> DATA.
REQ-019 DATA: SHALL sample at phase 7 of each bit, 16 ticks apart, LSB first; after 8 bits -> STOP.
REQ-020 STOP: at phase 7, rx=1 -> push byte, then IDLE; rx=0 -> set frame_err, discard byte, then BREAK.
REQ-021 BREAK: stay until rx=1, then -> IDLE.
REQ-022 rx_valid SHALL rise on the clk_sys cycle after the accepting stop-bit sample.
REQ-023 A push while the FIFO is full SHALL drop the byte and set overrun; FIFO contents are unchanged.
REQ-024 Push and pop on the same cycle with the FIFO full SHALL both succeed, without overrun.
REQ-025 rx_rd while the FIFO is empty SHALL be ignored.
REQ-026 A new error on the same cycle as err_clr SHALL win; the flag ends set.
REQ-027 FIFO pointers SHALL be log2(FIFO_DEPTH)+1 bits, wrapping naturally; full = MSBs differ and the rest are equal.
REQ-028 rx_data SHALL be stable while rx_valid=1 and there is no pop.

Reset
REQ-029 reset SHALL force: FSM=IDLE, FIFO empty, rx_valid=0, rx_data=0, frame_err=0, overrun=0, busy=0, synchronizer=1, counters=0.
REQ-030 reset during a byte SHALL discard the partial byte; reception restarts at the next falling edge after reset is released.

Configuration
REQ-031 Macro UART_RECEIVER_FIFO_EN defined: FIFO of FIFO_DEPTH entries.
REQ-032 Macro undefined: a single holding register (depth 1) replaces the FIFO; FIFO_DEPTH is ignored; the overrun and simultaneous push/pop rules apply with depth 1.

Structure
REQ-033 Package uart_receiver_pkg SHALL hold the FSM state enum typedef and the constants OVERSAMPLE=16, SAMPLE_PHASE=7 and DATA_BITS=8.
REQ-034 The FIFO SHALL be a sub-module, uart_receiver_fifo, parameterized by depth; the top holds the synchronizer, tick generator and FSM.

Verification (ce=1 every cycle, divisor=0, so 1 bit = 16 clk_sys)
REQ-035 Send 0x55, 8N1 -> rx_valid=1, rx_data=0x55, frame_err=0; pulse rx_rd -> rx_valid=0.
REQ-036 Drive rx low for 4 clk_sys cycles only -> no byte pushed; busy returns to 0 within 9 cycles.
REQ-037 Send 0xA3 with the stop bit low -> frame_err=1, rx_valid=0; BREAK is held until rx goes high; err_clr -> frame_err=0.
REQ-038 FIFO_EN: send 17 bytes 0x00..0x10 without reading -> 16 stored, overrun=1, reads return 0x00..0x0F in order.
REQ-039 FIFO full, hold rx_rd=1 on the push cycle of the next byte -> no overrun, count stays 16, the new byte is last.
REQ-040 Assert reset at DATA bit 4 of 0xFF, release, send 0x3C -> only 0x3C is received.
